sdes_round_ctrl: RTL and testbench

//  Iterative S-DES encrypt/decrypt engine: one job = 10-bit key + 8-bit block.

---
 rtl/sdes_pkg.sv | 82 ++++++++
 rtl/sdes_fk.sv | 20 ++
 rtl/sdes_round_ctrl.sv | 125 ++++++++++++
 tb/tb_sdes_round_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdes_pkg.sv
// Shared S-DES definitions: widths, permutation tables and helpers, S-boxes, controller states.
package sdes_pkg;
  localparam int KEY_W  = 10;
  localparam int BLK_W  = 8;
  localparam int HALF_W = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_KEY  = 3'd1,
    S_R1   = 3'd2,
    S_R2   = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  // Each table lists source bit positions (1 = MSB) in output order, MSB first.
  localparam int unsigned P10_TAB [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int unsigned P8_TAB  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
  localparam int unsigned IP_TAB  [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
  localparam int unsigned IPI_TAB [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
  localparam int unsigned EP_TAB  [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
  localparam int unsigned P4_TAB  [4]  = '{2, 4, 3, 1};

  // Row-major 4x4 boxes, flattened so the index is {row, col}.
  localparam logic [1:0] SBOX_TAB [2][16] = '{
    '{2'd1, 2'd0, 2'd3, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0,
      2'd0, 2'd2, 2'd1, 2'd3, 2'd3, 2'd1, 2'd3, 2'd2},
    '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd3,
      2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0, 2'd3}
  };

  function automatic logic [9:0] p10(input logic [9:0] d);
    logic [9:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r[4'(9 - i)] = d[4'(10 - P10_TAB[4'(i)])];
    return r;
  endfunction

  function automatic logic [7:0] p8(input logic [9:0] d);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[3'(7 - i)] = d[4'(10 - P8_TAB[3'(i)])];
    return r;
  endfunction

  function automatic logic [7:0] ip(input logic [7:0] d);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[3'(7 - i)] = d[3'(8 - IP_TAB[3'(i)])];
    return r;
  endfunction

  function automatic logic [7:0] ip_inv(input logic [7:0] d);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[3'(7 - i)] = d[3'(8 - IPI_TAB[3'(i)])];
    return r;
  endfunction

  function automatic logic [7:0] ep(input logic [3:0] d);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[3'(7 - i)] = d[2'(4 - EP_TAB[3'(i)])];
    return r;
  endfunction

  function automatic logic [3:0] p4(input logic [3:0] d);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[2'(3 - i)] = d[2'(4 - P4_TAB[2'(i)])];
    return r;
  endfunction

  // Rotate each 5-bit key half left by one.
  function automatic logic [9:0] ls1(input logic [9:0] k);
    return {k[8:5], k[9], k[3:0], k[4]};
  endfunction

  // Row from the outer bits, column from the inner bits of the nibble.
  function automatic logic [1:0] sbox(input logic box, input logic [3:0] n);
    return SBOX_TAB[box][{n[3], n[0], n[2], n[1]}];
  endfunction
endpackage

// File: rtl/sdes_fk.sv
// Combinational S-DES F-function: expands R, mixes in the subkey, runs S0/S1 and P4.
module sdes_fk
  import sdes_pkg::*;
(
  input  logic [HALF_W-1:0] r,
  input  logic [BLK_W-1:0]  subkey,
  output logic [HALF_W-1:0] sbox_val,
  output logic [HALF_W-1:0] mask
);
  logic [BLK_W-1:0] mixed;

  assign mixed = ep(r) ^ subkey;

  // Left nibble feeds S0, right nibble feeds S1.
  for (genvar gi = 0; gi < 2; gi++) begin : g_sbox
    assign sbox_val[HALF_W-1-2*gi -: 2] = sbox(1'(gi), mixed[BLK_W-1-4*gi -: 4]);
  end

  assign mask = p4(sbox_val);
endmodule

// File: rtl/sdes_round_ctrl.sv
// Iterative S-DES engine: key schedule, two rounds on a shared F-function, final permutation.
module sdes_round_ctrl
  import sdes_pkg::*;
#(
  parameter bit P_SBOX_REG = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_mode,
  input  logic [KEY_W-1:0] i_key,
  input  logic [BLK_W-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [BLK_W-1:0] o_data,
  output logic             o_busy
);
  state_t              state_reg;
  logic                phase_reg;
  logic                mode_reg;
  logic [KEY_W-1:0]    key_reg;
  logic [BLK_W-1:0]    k1_reg;
  logic [BLK_W-1:0]    k2_reg;
  logic [HALF_W-1:0]   l_reg;
  logic [HALF_W-1:0]   r_reg;
  logic [HALF_W-1:0]   sbox_reg;
  logic [BLK_W-1:0]    data_reg;
  logic                valid_reg;
  logic                ready_reg;
  logic                busy_reg;

  logic [BLK_W-1:0]    rkey;
  logic [HALF_W-1:0]   fk_sbox;
  logic [HALF_W-1:0]   fk_mask;
  logic [HALF_W-1:0]   mask_sel;
  logic                round_last;
  logic                state_bad;

  // Encrypt uses K1 then K2; decrypt reverses the order.
  assign rkey       = ((state_reg == S_R2) ^ mode_reg) ? k2_reg : k1_reg;
  assign mask_sel   = P_SBOX_REG ? p4(sbox_reg) : fk_mask;
  assign round_last = !P_SBOX_REG || phase_reg;
  assign state_bad  = (state_reg > S_OUT);

  sdes_fk u_fk (
    .r        (r_reg),
    .subkey   (rkey),
    .sbox_val (fk_sbox),
    .mask     (fk_mask)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst || state_bad) begin
      state_reg <= S_IDLE;
      phase_reg <= 1'b0;
      mode_reg  <= 1'b0;
      key_reg   <= '0;
      k1_reg    <= '0;
      k2_reg    <= '0;
      l_reg     <= '0;
      r_reg     <= '0;
      sbox_reg  <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (i_valid && ready_reg) begin
            key_reg          <= i_key;
            mode_reg         <= i_mode;
            {l_reg, r_reg}   <= ip(i_data);
            ready_reg        <= 1'b0;
            busy_reg         <= 1'b1;
            state_reg        <= S_KEY;
          end
        end
        S_KEY: begin
          k1_reg    <= p8(ls1(p10(key_reg)));
          k2_reg    <= p8(ls1(ls1(ls1(p10(key_reg)))));
          phase_reg <= 1'b0;
          state_reg <= S_R1;
        end
        S_R1: begin
          sbox_reg  <= fk_sbox;
          phase_reg <= ~phase_reg;
          if (round_last) begin
            l_reg     <= r_reg;
            r_reg     <= l_reg ^ mask_sel;
            phase_reg <= 1'b0;
            state_reg <= S_R2;
          end
        end
        S_R2: begin
          sbox_reg  <= fk_sbox;
          phase_reg <= ~phase_reg;
          // Result is formed from the post-round halves so o_data is ready on entry to S_OUT.
          if (round_last) begin
            l_reg     <= l_reg ^ mask_sel;
            phase_reg <= 1'b0;
            data_reg  <= ip_inv({l_reg ^ mask_sel, r_reg});
            valid_reg <= 1'b1;
            state_reg <= S_OUT;
          end
        end
        S_OUT: begin
          if (i_ready) begin
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ready = ready_reg;
  assign o_valid = valid_reg;
  assign o_data  = data_reg;
  assign o_busy  = busy_reg;
endmodule

// File: tb/tb_sdes_round_ctrl.sv
// Directed plus randomized checks of sdes_round_ctrl against a plain-arithmetic S-DES model.
module tb_sdes_round_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       i_valid0 = 1'b0, i_mode0 = 1'b0, i_ready0 = 1'b0;
  logic [9:0] i_key0 = '0;
  logic [7:0] i_data0 = '0;
  logic       o_ready0, o_valid0, o_busy0;
  logic [7:0] o_data0;

  logic       i_valid1 = 1'b0, i_mode1 = 1'b0, i_ready1 = 1'b0;
  logic [9:0] i_key1 = '0;
  logic [7:0] i_data1 = '0;
  logic       o_ready1, o_valid1, o_busy1;
  logic [7:0] o_data1;

  int  checks = 0;
  int  errors = 0;
  int  jobs = 0;
  time last_accept = 0;
  time prev_accept = 0;

  string sb0s = "1032321002133132";
  string sb1s = "0123201330102103";

  sdes_round_ctrl #(.P_SBOX_REG(1'b0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid0), .o_ready(o_ready0), .i_mode(i_mode0),
    .i_key(i_key0), .i_data(i_data0), .o_valid(o_valid0), .i_ready(i_ready0),
    .o_data(o_data0), .o_busy(o_busy0)
  );

  sdes_round_ctrl #(.P_SBOX_REG(1'b1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid1), .o_ready(o_ready1), .i_mode(i_mode1),
    .i_key(i_key1), .i_data(i_data1), .o_valid(o_valid1), .i_ready(i_ready1),
    .o_data(o_data1), .o_busy(o_busy1)
  );

  // Reference model: positions are 1-based from the MSB, 'a' stands for 10.
  function automatic int perm(int v, int in_w, string tab);
    int r;
    int p;
    r = 0;
    for (int i = 0; i < tab.len(); i++) begin
      p = (tab[i] == 8'h61) ? 10 : int'(tab[i]) - 48;
      r = (r << 1) | ((v >> (in_w - p)) & 1);
    end
    return r;
  endfunction

  function automatic int rot5(int h, int n);
    for (int i = 0; i < n; i++) h = ((h << 1) | (h >> 4)) & 31;
    return h;
  endfunction

  function automatic int subkey(int key, int which);
    int k10;
    k10 = perm(key, 10, "35274a1986");
    k10 = (rot5(k10 >> 5, (which == 1) ? 1 : 3) << 5) | rot5(k10 & 31, (which == 1) ? 1 : 3);
    return perm(k10, 10, "637485a9");
  endfunction

  function automatic int ffun(int r, int sk);
    int t, a, b, s0, s1;
    t  = perm(r, 4, "41232341") ^ sk;
    a  = t >> 4;
    b  = t & 15;
    s0 = int'(sb0s[((a >> 3) & 1) * 8 + (a & 1) * 4 + ((a >> 2) & 1) * 2 + ((a >> 1) & 1)]) - 48;
    s1 = int'(sb1s[((b >> 3) & 1) * 8 + (b & 1) * 4 + ((b >> 2) & 1) * 2 + ((b >> 1) & 1)]) - 48;
    return perm(s0 * 4 + s1, 4, "2431");
  endfunction

  function automatic int sdes(int key, int data, int dec);
    int ka, kb, t, l, r, tmp;
    ka  = subkey(key, (dec != 0) ? 2 : 1);
    kb  = subkey(key, (dec != 0) ? 1 : 2);
    t   = perm(data, 8, "26314857");
    l   = t >> 4;
    r   = t & 15;
    l   = l ^ ffun(r, ka);
    tmp = l; l = r; r = tmp;
    l   = l ^ ffun(r, kb);
    return perm(l * 16 + r, 8, "41357286");
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_job0(input logic m, input logic [9:0] k, input logic [7:0] d,
                          input int hold, input bit poke, output logic [7:0] res, output int lat);
    int wait_n;
    logic [7:0] first;
    wait_n = 0;
    while (!o_ready0 && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    chk("ready_before_job", 32'(o_ready0), 32'd1);
    i_mode0 = m; i_key0 = k; i_data0 = d; i_valid0 = 1'b1;
    @(posedge clk);
    prev_accept = last_accept;
    last_accept = $time;
    @(negedge clk);
    i_valid0 = 1'b0; i_mode0 = ~m; i_key0 = 10'($urandom); i_data0 = 8'($urandom);
    chk("busy_after_accept", 32'({o_busy0, o_ready0}), 32'd2);
    lat = 1;
    while (!o_valid0 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    first = o_data0;
    for (int c = 0; c < hold; c++) begin
      if (poke && c == 2) begin
        i_valid0 = 1'b1;
        i_data0  = 8'($urandom);
      end else begin
        i_valid0 = 1'b0;
      end
      @(negedge clk);
    end
    i_valid0 = 1'b0;
    if (hold > 0) begin
      chk("hold_data", 32'(o_data0), 32'(first));
      chk("hold_valid_ready", 32'({o_valid0, o_ready0}), 32'd2);
    end
    i_ready0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_ready0 = 1'b0;
    chk("handoff_state", 32'({o_ready0, o_valid0}), 32'd2);
    res = first;
    jobs++;
    $display("job %0d dut0 mode=%0d key=%b in=%h out=%h lat=%0d hold=%0d",
             jobs, m, k, d, res, lat, hold);
  endtask

  task automatic run_job1(input logic m, input logic [9:0] k, input logic [7:0] d,
                          output logic [7:0] res, output int lat);
    chk("ready_before_job1", 32'(o_ready1), 32'd1);
    i_mode1 = m; i_key1 = k; i_data1 = d; i_valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid1 = 1'b0; i_key1 = 10'($urandom); i_data1 = 8'($urandom);
    lat = 1;
    while (!o_valid1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = o_data1;
    i_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_ready1 = 1'b0;
    jobs++;
    $display("job %0d dut1 mode=%0d key=%b in=%h out=%h lat=%0d", jobs, m, k, d, res, lat);
  endtask

  initial begin
    logic [7:0] res;
    logic [7:0] ct [256];
    logic [9:0] k;
    logic [7:0] d;
    logic       m;
    int         lat;
    int         hold;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_dut0", 32'({o_ready0, o_valid0, o_busy0, o_data0}), 32'h400);
    chk("reset_dut1", 32'({o_ready1, o_valid1, o_busy1, o_data1}), 32'h400);

    // Known-answer encrypt and decrypt.
    run_job0(1'b0, 10'b1010000010, 8'b10010111, 0, 1'b0, res, lat);
    chk("t1_enc", 32'(res), 32'h38);
    chk("t1_latency", 32'(lat), 32'd4);
    chk("t1_k1", 32'(dut0.k1_reg), 32'hA4);
    chk("t1_k2", 32'(dut0.k2_reg), 32'h43);
    run_job0(1'b1, 10'b1010000010, 8'b00111000, 0, 1'b0, res, lat);
    chk("t2_dec", 32'(res), 32'h97);

    // Back-pressure with a stray request that must be ignored.
    run_job0(1'b0, 10'b0111010001, 8'hC5, 10, 1'b1, res, lat);
    chk("t3_res", 32'(res), 32'(sdes(int'(10'b0111010001), 32'hC5, 0)));
    i_ready0 = 1'b1;
    repeat (6) @(negedge clk);
    i_ready0 = 1'b0;
    chk("t3_idle_after", 32'({o_valid0, o_ready0, o_busy0}), 32'd2);

    // Reset while the engine is in the first round.
    i_mode0 = 1'b0; i_key0 = 10'h155; i_data0 = 8'h5A; i_valid0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_reset_mid", 32'({o_ready0, o_valid0, o_busy0, o_data0}), 32'h400);
    run_job0(1'b0, 10'b1010000010, 8'b10010111, 0, 1'b0, res, lat);
    chk("t4_after_reset", 32'(res), 32'h38);

    // Registered S-box build.
    run_job1(1'b0, 10'b1010000010, 8'b10010111, res, lat);
    chk("t5_enc", 32'(res), 32'h38);
    chk("t5_latency", 32'(lat), 32'd6);
    for (int i = 0; i < 6; i++) begin
      k = 10'($urandom); d = 8'($urandom); m = 1'($urandom);
      run_job1(m, k, d, res, lat);
      chk("t5_rand", 32'(res), 32'(sdes(int'(k), int'(d), int'(m))));
      chk("t5_rand_lat", 32'(lat), 32'd6);
    end

    // Randomized jobs with random back-pressure.
    for (int i = 0; i < 30; i++) begin
      k = 10'($urandom); d = 8'($urandom); m = 1'($urandom);
      hold = $urandom_range(0, 3);
      run_job0(m, k, d, hold, 1'b0, res, lat);
      chk("rand_res", 32'(res), 32'(sdes(int'(k), int'(d), int'(m))));
      chk("rand_lat", 32'(lat), 32'd4);
    end

    // Exhaustive block sweep, back-to-back, then round trip.
    for (int x = 0; x < 256; x++) begin
      run_job0(1'b0, 10'b1010000010, 8'(x), 0, 1'b0, res, lat);
      ct[x] = res;
      chk("sweep_enc", 32'(res), 32'(sdes(int'(10'b1010000010), x, 0)));
      if (x > 0) chk("sweep_throughput", 32'(last_accept - prev_accept), 32'd50);
    end
    for (int x = 0; x < 256; x++) begin
      run_job0(1'b1, 10'b1010000010, ct[x], 0, 1'b0, res, lat);
      chk("sweep_roundtrip", 32'(res), 32'(x));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
